// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants and helpers.
// Stage-count ceiling and valid-bit popcount.
package cpu_pipe_pkg;

  localparam int MAX_STAGES = 8;

  function automatic logic [3:0] popcount(
    input logic [MAX_STAGES-1:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_STAGES; i++)
      n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic slot: valid bit plus payload.
// Loads from its source when enabled, else holds or is killed.
module pipe_stage
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              kill,
  input  logic              src_v,
  input  logic [DATA_W-1:0] src_d,
  output logic              v,
  output logic [DATA_W-1:0] d
);

  // Slot register: take source on load, drop a held entry on kill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (load) begin
      v <= src_v;
      d <= src_d;
    end else if (kill) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic valid/ready register chain with partial flush.
// Flush kills the k youngest entries before they advance.
module elastic_pipe
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int FD_W   = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic [FD_W-1:0]   flush_depth,
  output logic [FD_W-1:0]   occupancy
);

  logic [STAGES-1:0] v;
  logic [DATA_W-1:0] d     [STAGES];
  logic [STAGES:0]   r;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] src_v;
  logic [DATA_W-1:0] src_d [STAGES];

  // Ready ripples back from the output so a full chain moves in one edge.
  always_comb begin : rdy_chain
    logic rr;
    rr        = out_ready;
    r         = '0;
    r[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rr   = !v[i] || rr;
      r[i] = rr;
    end
  end

  // A stage is killed when it is among the flush_depth youngest.
  always_comb begin
    kill = '0;
    for (int i = 0; i < STAGES; i++)
      kill[i] = flush && (flush_depth > FD_W'(i));
  end

  assign in_ready = r[0] && !flush && !reset;

  // Source of each stage; a killed entry travels on as a bubble.
  always_comb begin
    src_v[0] = in_valid && in_ready;
    src_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      src_v[i] = v[i-1] && !kill[i-1];
      src_d[i] = d[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stg
    pipe_stage #(
      .DATA_W (DATA_W)
    ) u_stg (
      .clk   (CLOCK_50),
      .rst   (reset),
      .load  (r[g]),
      .kill  (kill[g]),
      .src_v (src_v[g]),
      .src_d (src_d[g]),
      .v     (v[g]),
      .d     (d[g])
    );
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign occupancy = FD_W'(popcount(MAX_STAGES'(v)));

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed and scoreboard bench for elastic_pipe.
// Four-stage, 32-bit configuration.
module tb_elastic_pipe;

  logic        CLOCK_50;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;
  logic [2:0]  flush_depth;
  logic [2:0]  occupancy;

  int n_chk;
  int n_pass;
  logic [31:0] q[$];
  logic [31:0] exp_d;

  elastic_pipe #(
    .DATA_W (32),
    .STAGES (4),
    .FD_W   (3)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .flush       (flush),
    .flush_depth (flush_depth),
    .occupancy   (occupancy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    flush       = 1'b0;
    flush_depth = '0;

    // reset state
    #3;
    chk("rst_ov",  out_valid, 0);
    chk("rst_od",  out_data,  0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ir",  in_ready,  0);
    tick();
    reset = 1'b0;
    #1;

    // back-to-back stream 1..8
    for (int j = 0; j <= 12; j++) begin
      in_valid = (j < 8);
      in_data  = 32'(j + 1);
      #1;
      if (j < 8) chk("str_ir", in_ready, 1);
      if (j == 3) chk("str_lat", out_valid, 0);
      if (j >= 4 && j < 12) begin
        chk("str_ov", out_valid, 1);
        chk("str_od", out_data, 64'(j - 3));
      end
      if (j == 12) chk("str_end", out_valid, 0);
      tick();
    end

    // fill with A..D while stalled, E held off
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hA + 32'(k);
      #1;
      chk("fill_ir", in_ready, 1);
      tick();
    end
    in_data = 32'hE;
    #1;
    chk("full_occ", occupancy, 4);
    chk("full_ir",  in_ready,  0);
    chk("full_od",  out_data,  32'hA);
    tick();
    #1;
    chk("hold_occ", occupancy, 4);
    chk("hold_od",  out_data,  32'hA);
    out_ready = 1'b1;
    #1;
    chk("rel_ir", in_ready, 1);
    for (int k = 0; k < 5; k++) begin
      chk("rel_ov", out_valid, 1);
      chk("rel_od", out_data, 32'hA + 32'(k));
      tick();
      in_valid = 1'b0;
      #1;
    end
    chk("rel_occ", occupancy, 0);

    // partial flush: 0x13 oldest, 0x10 youngest
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h13 - 32'(k);
      tick();
    end
    in_valid    = 1'b0;
    flush       = 1'b1;
    flush_depth = 3'd2;
    out_ready   = 1'b1;
    #1;
    chk("fl2_od",  out_data,  32'h13);
    chk("fl2_ir",  in_ready,  0);
    chk("fl2_occ", occupancy, 4);
    tick();
    flush       = 1'b0;
    flush_depth = '0;
    #1;
    chk("fl2_occ1", occupancy, 1);
    chk("fl2_od1",  out_data,  32'h12);
    chk("fl2_ov1",  out_valid, 1);
    tick();
    #1;
    chk("fl2_ov2", out_valid, 0);

    // full flush with input offered
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h21 + 32'(k);
      tick();
    end
    flush       = 1'b1;
    flush_depth = 3'd7;
    in_data     = 32'h55;
    #1;
    chk("fl7_ir", in_ready, 0);
    tick();
    flush       = 1'b0;
    flush_depth = '0;
    in_valid    = 1'b0;
    #1;
    chk("fl7_occ", occupancy, 0);
    chk("fl7_ov",  out_valid, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("fl7_none", out_valid, 0);

    // async reset mid-stream
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h31 + 32'(k);
      tick();
    end
    #1;
    reset = 1'b1;
    #1;
    chk("ar_ov",  out_valid, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_od",  out_data,  0);
    chk("ar_ir",  in_ready,  0);
    #1;
    reset   = 1'b0;
    in_data = 32'h99;
    #1;
    chk("ar_ir2", in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1;
    chk("ar_lat", out_valid, 0);
    tick();
    #1;
    chk("ar_ov2", out_valid, 1);
    chk("ar_od2", out_data,  32'h99);
    tick();
    tick();

    // random handshakes vs reference queue
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      #1;
      chk("rnd_occ", occupancy, 64'(q.size()));
      chk("rnd_rng", (occupancy <= 3'd4), 1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_extra", 1, 0);
        end else begin
          exp_d = q.pop_front();
          chk("rnd_od", out_data, exp_d);
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("drn_extra", 1, 0);
        end else begin
          exp_d = q.pop_front();
          chk("drn_od", out_data, exp_d);
        end
      end
      tick();
    end
    chk("drn_q",  64'(q.size()), 0);
    chk("drn_ov", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
